// File: rtl/pad_group_arbiter_if.sv
// Bundle of requester and pad-side signals for the shared pad group arbiter.
// The arbiter uses the slave modport; the requesters and pads use the master modport.
interface pad_group_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req_0;
  logic             req_1;
  logic [WIDTH-1:0] out_0;
  logic [WIDTH-1:0] oe_0;
  logic [WIDTH-1:0] out_1;
  logic [WIDTH-1:0] oe_1;
  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] pad_out;
  logic [WIDTH-1:0] pad_oeb;
  logic [WIDTH-1:0] in_0;
  logic [WIDTH-1:0] in_1;
  logic             grant_0;
  logic             grant_1;
  logic             busy;

  modport slave (
    input  req_0, req_1, out_0, oe_0, out_1, oe_1, pad_in,
    output pad_out, pad_oeb, in_0, in_1, grant_0, grant_1, busy
  );

  modport master (
    output req_0, req_1, out_0, oe_0, out_1, oe_1, pad_in,
    input  pad_out, pad_oeb, in_0, in_1, grant_0, grant_1, busy
  );
endinterface

// File: rtl/pad_group_arbiter.sv
// Round-robin owner of one shared GPIO pad group between two requesters, with a
// bounded hold time and a tristated turnaround window on every hand-over.
module pad_group_arbiter #(
  parameter int WIDTH    = 8,
  parameter int TURN     = 2,
  parameter int MAX_HOLD = 16
) (
  input logic                 clock,
  input logic                 reset_n,
  pad_group_arbiter_if.slave  bus
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int TW = (TURN < 2) ? 1 : $clog2(TURN);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);
  localparam bit            PREEMPT   = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_TURN
  } state_t;

  state_t        state;
  logic          owner;
  logic          last;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] turn_cnt;
  logic          grant_0_q;
  logic          grant_1_q;
  logic          busy_q;

  logic any_req;
  logic winner;
  logic owner_req;
  logic other_req;
  logic preempt;

  // On a tie the requester that did not win last time takes the group.
  always_comb begin
    any_req   = bus.req_0 | bus.req_1;
    winner    = (bus.req_0 & bus.req_1) ? ~last : bus.req_1;
    owner_req = owner ? bus.req_1 : bus.req_0;
    other_req = owner ? bus.req_0 : bus.req_1;
    preempt   = PREEMPT && other_req && (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      hold_cnt  <= '0;
      turn_cnt  <= '0;
      grant_0_q <= 1'b0;
      grant_1_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            state     <= S_GRANT;
            owner     <= winner;
            last      <= winner;
            hold_cnt  <= '0;
            grant_0_q <= ~winner;
            grant_1_q <= winner;
            busy_q    <= 1'b1;
          end
        end
        S_GRANT: begin
          // Release and preempt lead to the same place, so one branch serves both.
          if (!owner_req || preempt) begin
            state     <= S_TURN;
            turn_cnt  <= '0;
            grant_0_q <= 1'b0;
            grant_1_q <= 1'b0;
          end else if (other_req && (hold_cnt != '1)) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_TURN: begin
          if (turn_cnt == TURN_LAST) begin
            if (any_req) begin
              state     <= S_GRANT;
              owner     <= winner;
              last      <= winner;
              hold_cnt  <= '0;
              grant_0_q <= ~winner;
              grant_1_q <= winner;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            turn_cnt <= turn_cnt + TW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant_0 = grant_0_q;
  assign bus.grant_1 = grant_1_q;
  assign bus.busy    = busy_q;

  // Pad routing follows the registered state directly so data sees no extra latency.
  always_comb begin
    bus.pad_out = '0;
    bus.pad_oeb = '1;
    bus.in_0    = '0;
    bus.in_1    = '0;
    if (state == S_GRANT) begin
      if (owner) begin
        bus.pad_out = bus.out_1;
        bus.pad_oeb = ~bus.oe_1;
        bus.in_1    = bus.pad_in;
      end else begin
        bus.pad_out = bus.out_0;
        bus.pad_oeb = ~bus.oe_0;
        bus.in_0    = bus.pad_in;
      end
    end
  end

endmodule
